// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU decode and the iterative multiply/divide unit:
// alu_op classes, ALU control codes, funct codes, MDU FSM states and latched operation flags.
package alu_pkg;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} mdu_state_e;

  typedef struct packed {
    logic sgn;
    logic div;
    logic neg_a;
    logic neg_b;
    logic b_zero;
  } mdu_op_t;

  function automatic logic is_mdu_start(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Magnitude-only radix-2 shift-add multiplier / restoring divider sharing one adder.
// One step per cycle when step=1; start loads operands; signs are handled by the caller.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode_div,
  input  logic             step,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi_raw,
  output logic [WIDTH-1:0] lo_raw
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             div_q, div_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   add_x, add_y;
  logic             add_cin;
  logic [WIDTH+1:0] add_res;

  assign rem_sh = {acc_q, sh_q[WIDTH-1]};

  // Divide subtracts via two's complement; carry-out set means no borrow.
  always_comb begin
    if (div_q) begin
      add_x   = rem_sh;
      add_y   = ~{1'b0, m_q};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, acc_q};
      add_y   = sh_q[0] ? {1'b0, m_q} : '0;
      add_cin = 1'b0;
    end
  end

  assign add_res = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+2)'(add_cin);

  always_comb begin
    acc_d = acc_q;
    sh_d  = sh_q;
    m_d   = m_q;
    div_d = div_q;
    if (start) begin
      acc_d = '0;
      div_d = mode_div;
      m_d   = mode_div ? op_b : op_a;
      sh_d  = mode_div ? op_a : op_b;
    end else if (step) begin
      if (div_q) begin
        acc_d = add_res[WIDTH+1] ? add_res[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], add_res[WIDTH+1]};
      end else begin
        acc_d = add_res[WIDTH:1];
        sh_d  = {add_res[0], sh_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sh_q  <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      m_q   <= m_d;
      div_q <= div_d;
    end
  end

  assign hi_raw = acc_q;
  assign lo_raw = sh_q;

endmodule

// File: rtl/alu_mdu_ctrl.sv
// EX-stage ALU decode plus iterative MULT/DIV with HI/LO; results land WIDTH+2 edges after issue.
// MDU starts and MFHI/MFLO stall while busy; all other instructions flow in parallel.
module alu_mdu_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       fn_field,
  input  logic             valid,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [3:0]       alu_ctrl,
  output logic             illegal,
  output logic             mdu_sel,
  output logic [WIDTH-1:0] mdu_rdata,
  output logic             stall,
  output logic             busy
);
  import alu_pkg::*;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  mdu_op_t          op_q, op_d;

  logic             is_rtype, start_fn, rd_hi, rd_lo, start, step;
  logic             sgn_mode, a_neg, b_neg, diff_sign;
  logic [WIDTH-1:0] a_mag, b_mag, hi_raw, lo_raw, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;

  always_comb begin
    alu_ctrl = ALU_AND;
    illegal  = 1'b0;
    case (alu_op)
      ALUOP_MEM: alu_ctrl = ALU_ADD;
      ALUOP_BEQ: alu_ctrl = ALU_SUB;
      ALUOP_ORI: alu_ctrl = ALU_OR;
      default: begin
        case (fn_field)
          FN_ADD, FN_ADDU: alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: alu_ctrl = ALU_SUB;
          FN_AND:          alu_ctrl = ALU_AND;
          FN_OR:           alu_ctrl = ALU_OR;
          FN_XOR:          alu_ctrl = ALU_XOR;
          FN_NOR:          alu_ctrl = ALU_NOR;
          FN_SLT:          alu_ctrl = ALU_SLT;
          FN_SLTU:         alu_ctrl = ALU_SLTU;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MFLO: alu_ctrl = ALU_ADD;
          default:         illegal  = 1'b1;
        endcase
      end
    endcase
  end

  assign is_rtype = (alu_op == ALUOP_RTYPE);
  assign start_fn = is_rtype && is_mdu_start(fn_field);
  assign rd_hi    = is_rtype && (fn_field == FN_MFHI);
  assign rd_lo    = is_rtype && (fn_field == FN_MFLO);
  assign busy     = (state_q != IDLE);
  assign stall    = busy && valid && (start_fn || rd_hi || rd_lo);
  assign start    = valid && start_fn && !busy;
  assign step     = (state_q == MUL) || (state_q == DIV);

  assign mdu_sel   = valid && (rd_hi || rd_lo);
  assign mdu_rdata = (valid && rd_hi) ? hi_q : ((valid && rd_lo) ? lo_q : '0);

  // Odd funct bit selects the unsigned variants; |MIN| fits as an unsigned magnitude.
  assign sgn_mode = !fn_field[0];
  assign a_neg    = sgn_mode && src_a[WIDTH-1];
  assign b_neg    = sgn_mode && src_b[WIDTH-1];
  assign a_mag    = a_neg ? -src_a : src_a;
  assign b_mag    = b_neg ? -src_b : src_b;

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode_div (fn_field[1]),
    .step     (step),
    .op_a     (a_mag),
    .op_b     (b_mag),
    .hi_raw   (hi_raw),
    .lo_raw   (lo_raw)
  );

  assign diff_sign = op_q.sgn && (op_q.neg_a ^ op_q.neg_b);
  assign prod_raw  = {hi_raw, lo_raw};
  assign prod_fix  = diff_sign ? -prod_raw : prod_raw;
  assign quo_fix   = op_q.b_zero ? '1 : (diff_sign ? -lo_raw : lo_raw);
  assign rem_fix   = (op_q.sgn && op_q.neg_a) ? -hi_raw : hi_raw;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = '{sgn: sgn_mode, div: fn_field[1], neg_a: a_neg, neg_b: b_neg,
                      b_zero: (src_b == '0)};
          cnt_d   = CNT_W'(WIDTH);
          state_d = fn_field[1] ? DIV : MUL;
        end
      end
      MUL, DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIXUP;
      end
      default: begin
        if (op_q.div) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Randomised and directed bench for alu_mdu_ctrl against an arithmetic reference model.
module tb_alu_mdu_ctrl;

  localparam int WIDTH = 32;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD  = 6'b100000;

  logic             clk, rst_n, valid, illegal, mdu_sel, stall, busy;
  logic [1:0]       alu_op;
  logic [5:0]       fn_field;
  logic [WIDTH-1:0] src_a, src_b, mdu_rdata;
  logic [3:0]       alu_ctrl;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycles of busyness left, architectural HI/LO, pending result.
  int          m_rem;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        obs_stall, obs_busy;
  logic [31:0] obs_rdata;

  alu_mdu_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_op    (alu_op),
    .fn_field  (fn_field),
    .valid     (valid),
    .src_a     (src_a),
    .src_b     (src_b),
    .alu_ctrl  (alu_ctrl),
    .illegal   (illegal),
    .mdu_sel   (mdu_sel),
    .mdu_rdata (mdu_rdata),
    .stall     (stall),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic void exp_decode(input logic [1:0] op, input logic [5:0] fn,
                                     output logic [3:0] c, output logic il);
    il = 1'b0;
    c  = 4'b0000;
    case (op)
      2'b00: c = 4'b0010;
      2'b01: c = 4'b0110;
      2'b11: c = 4'b0001;
      default: begin
        case (fn)
          6'b100000, 6'b100001: c = 4'b0010;
          6'b100010, 6'b100011: c = 4'b0110;
          6'b100100: c = 4'b0000;
          6'b100101: c = 4'b0001;
          6'b100110: c = 4'b0011;
          6'b100111: c = 4'b1100;
          6'b101010: c = 4'b0111;
          6'b101011: c = 4'b1000;
          6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b010000, 6'b010010: c = 4'b0010;
          default: il = 1'b1;
        endcase
      end
    endcase
  endfunction

  function automatic void mdu_model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    logic [63:0] v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    v  = '0;
    case (fn)
      F_MULT:  begin p = sa * sb; v = p; end
      F_MULTU: begin up = ua * ub; v = up; end
      F_DIV: begin
        if (b == 32'd0) v = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) v = {32'd0, 32'h8000_0000};
        else begin q = sa / sb; r = sa % sb; v = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (b == 32'd0) v = {a, 32'hFFFF_FFFF};
        else begin uq = ua / ub; ur = ua % ub; v = {ur[31:0], uq[31:0]}; end
      end
    endcase
    hi = v[63:32];
    lo = v[31:0];
  endfunction

  // One pipeline cycle: drive, compare against the model, then advance the model at the edge.
  task automatic cyc(input logic [1:0] op, input logic [5:0] fn, input logic v,
                     input logic [31:0] a, input logic [31:0] b);
    logic [3:0] ec;
    logic ei, est, emf, es;
    @(negedge clk);
    alu_op = op; fn_field = fn; valid = v; src_a = a; src_b = b;
    #1;
    exp_decode(op, fn, ec, ei);
    est = v && op == 2'b10 && (fn == F_MULT || fn == F_MULTU || fn == F_DIV || fn == F_DIVU);
    emf = v && op == 2'b10 && (fn == F_MFHI || fn == F_MFLO);
    es  = (m_rem != 0) && (est || emf);
    chk("alu_ctrl", alu_ctrl, ec);
    chk("illegal", illegal, ei);
    chk("busy", busy, m_rem != 0);
    chk("stall", stall, es);
    if (!es) begin
      chk("mdu_sel", mdu_sel, emf);
      chk("mdu_rdata", mdu_rdata, !emf ? 32'd0 : (fn == F_MFHI ? m_hi : m_lo));
    end
    obs_stall = stall; obs_busy = busy; obs_rdata = mdu_rdata;
    @(posedge clk);
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (est) begin
      mdu_model(fn, a, b, p_hi, p_lo);
      m_rem = WIDTH + 1;
    end
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 6'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic read_hl(input string nm, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    cyc(2'b10, F_MFHI, 1'b1, 32'd0, 32'd0);
    chk({nm, "_hi"}, obs_rdata, exp_hi);
    cyc(2'b10, F_MFLO, 1'b1, 32'd0, 32'd0);
    chk({nm, "_lo"}, obs_rdata, exp_lo);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    logic done;
    logic [5:0] fn;
    logic [1:0] op;
    logic [31:0] th, tl;
    rst_n = 1'b1; valid = 1'b0; alu_op = 2'b00; fn_field = 6'd0; src_a = '0; src_b = '0;
    m_rem = 0; m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0;
    #2 rst_n = 1'b0;
    alu_op = 2'b10; fn_field = F_MFHI; valid = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_rdata", mdu_rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int f = 0; f < 64; f++) cyc(2'b10, 6'(f), 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    alu_op = 2'b10; fn_field = 6'b000001; valid = 1'b0;
    #1;
    chk("undef_ctrl", alu_ctrl, 4'b0000);
    chk("undef_illegal", illegal, 1'b1);
    fn_field = 6'b101010;
    #1;
    chk("slt_ctrl", alu_ctrl, 4'b0111);

    mdu_model(F_MULT, -32'sd3, 32'd7, th, tl);
    chk("model_mult", {th, tl}, 64'hFFFF_FFFF_FFFF_FFEB);
    mdu_model(F_DIV, -32'sd7, 32'd2, th, tl);
    chk("model_div", {th, tl}, 64'hFFFF_FFFF_FFFF_FFFD);

    cyc(2'b10, F_MULT, 1'b1, -32'sd3, 32'd7);
    nops(33);
    chk("mult_fixup_busy", obs_busy, 1'b1);
    read_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    cyc(2'b10, F_MULTU, 1'b1, 32'hFFFF_FFFF, 32'd2);
    cyc(2'b10, F_ADD, 1'b1, 32'd1, 32'd2);
    chk("add_no_stall", obs_stall, 1'b0);
    nops(1);
    n = 0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      cyc(2'b10, F_MFLO, 1'b1, 32'd0, 32'd0);
      if (obs_stall) n++; else done = 1'b1;
    end
    chk("mflo_released", done, 1'b1);
    chk("mflo_stall_cycles", n, 31);
    chk("mflo_new_lo", obs_rdata, 32'hFFFF_FFFE);
    read_hl("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    cyc(2'b10, F_DIVU, 1'b1, 32'd5, 32'd0);
    nops(33);
    read_hl("divu0", 32'h0000_0005, 32'hFFFF_FFFF);

    cyc(2'b10, F_MULT, 1'b1, 32'd5, 32'd6);
    n = 0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      cyc(2'b10, F_DIV, 1'b1, -32'sd7, 32'd2);
      if (obs_stall) n++; else done = 1'b1;
    end
    chk("b2b_accepted", done, 1'b1);
    chk("b2b_stall_cycles", n, 33);
    nops(33);
    read_hl("b2b_div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    cyc(2'b10, F_DIV, 1'b1, 32'd100, 32'd7);
    nops(5);
    @(negedge clk);
    alu_op = 2'b10; fn_field = F_MFLO; valid = 1'b1; src_a = '0; src_b = '0;
    #1;
    chk("pre_rst_busy", busy, m_rem != 0);
    chk("pre_rst_stall", stall, m_rem != 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_stall", stall, 1'b0);
    chk("arst_lo", mdu_rdata, 32'd0);
    m_rem = 0; m_hi = '0; m_lo = '0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    read_hl("arst_hl", 32'd0, 32'd0);
    cyc(2'b10, F_MULT, 1'b1, -32'sd3, 32'd7);
    nops(33);
    read_hl("post_rst_mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    cyc(2'b10, F_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    nops(33);
    read_hl("min_neg1", 32'd0, 32'h8000_0000);

    for (int i = 0; i < 3000; i++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 7) op = 2'b10;
      case ($urandom_range(0, 9))
        0: fn = F_MULT;
        1: fn = F_MULTU;
        2: fn = F_DIV;
        3: fn = F_DIVU;
        4: fn = F_MFHI;
        5: fn = F_MFLO;
        6: fn = F_ADD;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      cyc(op, fn, $urandom_range(0, 3) != 0, rnd_val(), rnd_val());
    end
    nops(40);
    read_hl("final", m_hi, m_lo);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
